branch_predictor: RTL

Fetch-side branch predictor and branch target buffer (BTB) that supplies the `prediction` bit consumed by `branchHandler` in EX, and is trained by the resolved outcome coming back from EX. It holds a direct-mapped table of 2^INDEX_BITS entries: valid bit, tag, target and a 2-bit saturating counter. Lookup is combinational in IF; training is registered at the clock edge. It also keeps branch and misprediction counters for performance monitoring.

---
 rtl/bp_pkg.sv | 18 +
 rtl/branch_predictor_sat_counter2.sv | 21 ++
 rtl/branch_predictor.sv | 109 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions: 2-bit counter encodings, EX opcodes
// and default table geometry.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [3:0] BRANCH = 4'b0010;
    localparam logic [3:0] ALU_R  = 4'b1100;
    localparam logic [3:0] ALU_I  = 4'b0100;

    localparam int unsigned DEFAULT_INDEX_BITS = 4;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_e cur_i,
    input  logic taken_i,
    output ctr_e next_c
);

    always_comb begin
        next_c = cur_i;
        unique case (cur_i)
            SNT: next_c = taken_i ? WNT : SNT;
            WNT: next_c = taken_i ? WT  : SNT;
            WT:  next_c = taken_i ? ST  : WNT;
            ST:  next_c = taken_i ? ST  : WT;
            default: next_c = cur_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup at fetch,
// registered training from resolved EX branches, plus saturating statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned DBITS      = 32,
    parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DBITS-1:0]    if_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [DBITS-1:0]    pred_target,
    input  logic                upd_valid,
    input  logic [DBITS-1:0]    upd_pc,
    input  logic                upd_taken,
    input  logic [DBITS-1:0]    upd_target,
    input  logic                upd_mispredict,
    output logic [CNT_BITS-1:0] branch_count,
    output logic [CNT_BITS-1:0] mispred_count
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W   = DBITS - INDEX_BITS - 2;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [DBITS-1:0]      target_q [ENTRIES];
    ctr_e                  ctr_q    [ENTRIES];
    logic [CNT_BITS-1:0]   branch_count_q, branch_count_d;
    logic [CNT_BITS-1:0]   mispred_count_q, mispred_count_d;

    logic [INDEX_BITS-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0]      if_tag, upd_tag;
    ctr_e                  if_ctr, upd_ctr, upd_ctr_next;
    logic                  upd_hit;
    logic [1:0]            unused_pc_lsbs;

    assign if_idx  = if_pc[INDEX_BITS+1:2];
    assign if_tag  = if_pc[DBITS-1:INDEX_BITS+2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[DBITS-1:INDEX_BITS+2];
    assign unused_pc_lsbs = upd_pc[1:0];

    // Lookup reads registered state only; no bypass from a same-cycle update.
    assign if_ctr      = ctr_q[if_idx];
    assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = pred_hit && if_ctr[1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + DBITS'(4);

    assign upd_ctr = ctr_q[upd_idx];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    sat_counter2 u_sat_counter2 (
        .cur_i   (upd_ctr),
        .taken_i (upd_taken),
        .next_c  (upd_ctr_next)
    );

    always_comb begin
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        if (upd_valid) begin
            if (branch_count_q != '1) begin
                branch_count_d = branch_count_q + CNT_BITS'(1);
            end
            if (upd_mispredict && (mispred_count_q != '1)) begin
                mispred_count_d = mispred_count_q + CNT_BITS'(1);
            end
        end
    end

    // Valid bits, counters and statistics are the only reset state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q         <= '0;
            branch_count_q  <= '0;
            mispred_count_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= WNT;
            end
        end else begin
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
            if (upd_valid) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= upd_ctr_next;
                end else if (upd_taken) begin
                    valid_q[upd_idx] <= 1'b1;
                    ctr_q[upd_idx]   <= WT;
                end
            end
        end
    end

    // A taken update either refreshes a hit (tag unchanged) or allocates.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    assign branch_count  = branch_count_q;
    assign mispred_count = mispred_count_q;

endmodule
